// File: rtl/jtkcpu_intctl_pkg.sv
// Shared constants for the KCPU interrupt scheduler: vector nibbles, CC bit
// positions and the scheduler state encoding.
package jtkcpu_intctl_pkg;

  localparam logic [3:0] VEC_NMI  = 4'hC;
  localparam logic [3:0] VEC_IRQ  = 4'h8;
  localparam logic [3:0] VEC_FIRQ = 4'h6;

  localparam int CC_F = 6;
  localparam int CC_I = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_C = 2'd1,
    ST_WAIT_S = 2'd2,
    ST_TAKEN  = 2'd3
  } state_e;

endpackage

// File: rtl/jtkcpu_intsync.sv
// Clock-enable qualified synchroniser for one active-low interrupt line.
// Every stage presets to 1 so a line reads inactive straight out of reset.
module jtkcpu_intsync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic din_i,
  output logic dout_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else if (cen) begin
      sync_q[0] <= din_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign dout_o = sync_q[STAGES-1];

endmodule

// File: rtl/jtkcpu_intctl.sv
// KCPU interrupt scheduler: decides at instruction boundaries and CWAI/SYNC
// waits whether the microcode enters interrupt service, and with which vector.
module jtkcpu_intctl
  import jtkcpu_intctl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       nmi_n,
  input  logic       firq_n,
  input  logic       irq_n,
  input  logic [7:0] cc,
  input  logic       s_wr,
  input  logic       ni,
  input  logic       wait_cwai,
  input  logic       wait_sync,
  input  logic       int_ack,
  output logic       intsrv,
  output logic [3:0] intvec,
  output logic       int_fast,
  output logic       wait_rel,
  output logic       nmi_armed
);

  logic nmi_s, firq_s, irq_s;

  jtkcpu_intsync #(.STAGES(SYNC_STAGES)) u_sync_nmi (
    .clk(clk), .rst(rst), .cen(cen), .din_i(nmi_n), .dout_o(nmi_s)
  );
  jtkcpu_intsync #(.STAGES(SYNC_STAGES)) u_sync_firq (
    .clk(clk), .rst(rst), .cen(cen), .din_i(firq_n), .dout_o(firq_s)
  );
  jtkcpu_intsync #(.STAGES(SYNC_STAGES)) u_sync_irq (
    .clk(clk), .rst(rst), .cen(cen), .din_i(irq_n), .dout_o(irq_s)
  );

  state_e     state_q;
  logic       intsrv_q, int_fast_q, wait_rel_q;
  logic [3:0] intvec_q;
  logic       nmi_last_q, nmi_pend_q, nmi_armed_q;
  logic       nmi_pend_d, nmi_fall, nmi_clr;
  logic       nmi_rdy, firq_rdy, irq_rdy, any_rdy, any_low, take;
  logic [3:0] sel_vec;
  logic       sel_fast;

  // Only CC.F and CC.I matter here; the rest of the CC byte is deliberately ignored.
  logic unused_cc;
  assign unused_cc = ^{cc[7], cc[5], cc[3:0]};

  // A fresh edge in the acknowledge cycle beats the clear, so it is never lost.
  always_comb begin
    nmi_fall   = nmi_last_q & ~nmi_s;
    nmi_clr    = (state_q == ST_TAKEN) && int_ack && (intvec_q == VEC_NMI);
    nmi_pend_d = (nmi_fall & nmi_armed_q) | (nmi_pend_q & ~nmi_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_last_q  <= 1'b1;
      nmi_pend_q  <= 1'b0;
      nmi_armed_q <= 1'b0;
    end else if (cen) begin
      nmi_last_q <= nmi_s;
      nmi_pend_q <= nmi_pend_d;
      if (s_wr) nmi_armed_q <= 1'b1;
    end
  end

  always_comb begin
    nmi_rdy  = nmi_pend_q;
    firq_rdy = ~firq_s & ~cc[CC_F];
    irq_rdy  = ~irq_s & ~cc[CC_I];
    any_rdy  = nmi_rdy | firq_rdy | irq_rdy;
    any_low  = nmi_pend_q | ~firq_s | ~irq_s;
    sel_vec  = VEC_IRQ;
    sel_fast = 1'b0;
    if (nmi_rdy) begin
      sel_vec = VEC_NMI;
    end else if (firq_rdy) begin
      sel_vec  = VEC_FIRQ;
      sel_fast = 1'b1;
    end
    take = 1'b0;
    case (state_q)
      ST_IDLE:   take = ni & any_rdy;
      ST_WAIT_C: take = any_rdy;
      ST_WAIT_S: take = any_rdy;
      default:   take = 1'b0;
    endcase
  end

  // A SYNC wait woken by a masked line resumes execution through wait_rel instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      intsrv_q   <= 1'b0;
      intvec_q   <= 4'h0;
      int_fast_q <= 1'b0;
      wait_rel_q <= 1'b0;
    end else if (cen) begin
      wait_rel_q <= 1'b0;
      if (take) begin
        state_q    <= ST_TAKEN;
        intsrv_q   <= 1'b1;
        intvec_q   <= sel_vec;
        int_fast_q <= sel_fast;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (wait_cwai)      state_q <= ST_WAIT_C;
            else if (wait_sync) state_q <= ST_WAIT_S;
          end
          ST_WAIT_C: state_q <= ST_WAIT_C;
          ST_WAIT_S: begin
            if (any_low) begin
              wait_rel_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
          ST_TAKEN: begin
            if (int_ack) begin
              intsrv_q <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign intsrv    = intsrv_q;
  assign intvec    = intvec_q;
  assign int_fast  = int_fast_q;
  assign wait_rel  = wait_rel_q;
  assign nmi_armed = nmi_armed_q;

endmodule

// File: tb/tb_jtkcpu_intctl.sv
// Directed bench for the KCPU interrupt scheduler with hand-computed
// expectations for a two-stage synchroniser.
module tb_jtkcpu_intctl;

  logic       clk = 1'b0;
  logic       rst, cen, nmi_n, firq_n, irq_n, s_wr, ni;
  logic       wait_cwai, wait_sync, int_ack;
  logic [7:0] cc;
  logic       intsrv, int_fast, wait_rel, nmi_armed;
  logic [3:0] intvec;

  int testsRun  = 0;
  int testsFail = 0;
  int seenSrv;

  always #5 clk = ~clk;

  jtkcpu_intctl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .nmi_n(nmi_n), .firq_n(firq_n), .irq_n(irq_n),
    .cc(cc), .s_wr(s_wr), .ni(ni),
    .wait_cwai(wait_cwai), .wait_sync(wait_sync), .int_ack(int_ack),
    .intsrv(intsrv), .intvec(intvec), .int_fast(int_fast),
    .wait_rel(wait_rel), .nmi_armed(nmi_armed)
  );

  // Advance n rising edges and settle 1ns past the last one before sampling.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic pulseNi();
    ni = 1'b1;
    applyStimulus(1);
    ni = 1'b0;
  endtask

  task automatic pulseAck();
    int_ack = 1'b1;
    applyStimulus(1);
    int_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; nmi_n = 1'b1; firq_n = 1'b1; irq_n = 1'b1;
    cc = 8'h00; s_wr = 1'b0; ni = 1'b0; wait_cwai = 1'b0; wait_sync = 1'b0;
    int_ack = 1'b0;
    applyStimulus(2);
    rst = 1'b0;
    checkOutput("rst_intsrv",   {7'd0, intsrv},    8'h00);
    checkOutput("rst_intvec",   {4'd0, intvec},    8'h00);
    checkOutput("rst_int_fast", {7'd0, int_fast},  8'h00);
    checkOutput("rst_wait_rel", {7'd0, wait_rel},  8'h00);
    checkOutput("rst_armed",    {7'd0, nmi_armed}, 8'h00);

    // NMI before arming is discarded
    cc = 8'h50;
    nmi_n = 1'b0; applyStimulus(4);
    nmi_n = 1'b1; applyStimulus(4);
    seenSrv = 0;
    for (int i = 0; i < 10; i++) begin
      pulseNi();
      if (intsrv) seenSrv = 1;
      applyStimulus(1);
    end
    checkOutput("nmi_disarmed", seenSrv[7:0], 8'h00);
    checkOutput("armed_before", {7'd0, nmi_armed}, 8'h00);

    s_wr = 1'b1; applyStimulus(1); s_wr = 1'b0;
    checkOutput("armed_after", {7'd0, nmi_armed}, 8'h01);
    nmi_n = 1'b0; applyStimulus(4);
    nmi_n = 1'b1;
    pulseNi();
    checkOutput("nmi_intsrv", {7'd0, intsrv},   8'h01);
    checkOutput("nmi_vec",    {4'd0, intvec},   8'h0C);
    checkOutput("nmi_fast",   {7'd0, int_fast}, 8'h00);
    applyStimulus(2);
    checkOutput("nmi_hold", {7'd0, intsrv}, 8'h01);
    pulseAck();
    checkOutput("nmi_ack", {7'd0, intsrv}, 8'h00);
    pulseNi();
    checkOutput("nmi_cleared", {7'd0, intsrv}, 8'h00);

    // FIRQ beats IRQ, then masked FIRQ lets IRQ through
    cc = 8'h00; irq_n = 1'b0; firq_n = 1'b0;
    applyStimulus(3);
    pulseNi();
    checkOutput("firq_intsrv", {7'd0, intsrv},   8'h01);
    checkOutput("firq_vec",    {4'd0, intvec},   8'h06);
    checkOutput("firq_fast",   {7'd0, int_fast}, 8'h01);
    cc = 8'h40;
    pulseAck();
    checkOutput("firq_ack", {7'd0, intsrv}, 8'h00);
    pulseNi();
    checkOutput("irq_vec",  {4'd0, intvec},   8'h08);
    checkOutput("irq_fast", {7'd0, int_fast}, 8'h00);
    irq_n = 1'b1;
    applyStimulus(4);
    checkOutput("level_drop_srv", {7'd0, intsrv}, 8'h01);
    checkOutput("level_drop_vec", {4'd0, intvec}, 8'h08);
    pulseAck();
    firq_n = 1'b1;

    // IRQ mask honoured at ni
    cc = 8'h10; irq_n = 1'b0;
    applyStimulus(3);
    pulseNi();
    checkOutput("irq_masked", {7'd0, intsrv}, 8'h00);
    cc = 8'h00;
    pulseNi();
    checkOutput("irq_unmask_srv", {7'd0, intsrv}, 8'h01);
    checkOutput("irq_unmask_vec", {4'd0, intvec}, 8'h08);
    pulseAck();

    // SYNC woken by a masked line releases without service
    cc = 8'h10;
    wait_sync = 1'b1; applyStimulus(1); wait_sync = 1'b0;
    applyStimulus(1);
    checkOutput("sync_rel",    {7'd0, wait_rel}, 8'h01);
    checkOutput("sync_nosrv",  {7'd0, intsrv},   8'h00);
    applyStimulus(1);
    checkOutput("sync_rel_end", {7'd0, wait_rel}, 8'h00);
    irq_n = 1'b1;
    applyStimulus(3);

    // CWAI serviced by FIRQ after synchroniser latency
    cc = 8'h00;
    wait_cwai = 1'b1; applyStimulus(1); wait_cwai = 1'b0;
    applyStimulus(20);
    checkOutput("cwai_idle", {7'd0, intsrv}, 8'h00);
    firq_n = 1'b0;
    applyStimulus(2);
    checkOutput("cwai_early", {7'd0, intsrv}, 8'h00);
    applyStimulus(1);
    checkOutput("cwai_srv", {7'd0, intsrv}, 8'h01);
    checkOutput("cwai_vec", {4'd0, intvec}, 8'h06);
    pulseAck();
    firq_n = 1'b1;
    applyStimulus(3);

    // NMI edge coinciding with acknowledge stays pending
    nmi_n = 1'b0; applyStimulus(4);
    nmi_n = 1'b1; applyStimulus(3);
    pulseNi();
    checkOutput("nmi2_vec", {4'd0, intvec}, 8'h0C);
    nmi_n = 1'b0;
    applyStimulus(2);
    pulseAck();
    checkOutput("nmi2_ack", {7'd0, intsrv}, 8'h00);
    nmi_n = 1'b1;
    applyStimulus(3);
    pulseNi();
    checkOutput("nmi2_again_srv", {7'd0, intsrv}, 8'h01);
    checkOutput("nmi2_again_vec", {4'd0, intvec}, 8'h0C);
    pulseAck();
    checkOutput("nmi2_done", {7'd0, intsrv}, 8'h00);

    // cen=0 freezes state; reset still acts
    irq_n = 1'b0;
    applyStimulus(3);
    pulseNi();
    checkOutput("cen_pre_vec", {4'd0, intvec}, 8'h08);
    cen = 1'b0; int_ack = 1'b1; ni = 1'b1; irq_n = 1'b1;
    applyStimulus(3);
    checkOutput("cen_hold_srv", {7'd0, intsrv}, 8'h01);
    checkOutput("cen_hold_vec", {4'd0, intvec}, 8'h08);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0; cen = 1'b1; int_ack = 1'b0; ni = 1'b0;
    checkOutput("cen_rst_srv",   {7'd0, intsrv},    8'h00);
    checkOutput("cen_rst_vec",   {4'd0, intvec},    8'h00);
    checkOutput("cen_rst_armed", {7'd0, nmi_armed}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
